// File: rtl/mac_ifm_encoder_pkg.sv
// Shared types and constants for the MAC lane IFM encoder: datatypes,
// lane word layout, monitor counters and per-datatype beat counts.
package mac_ifm_encoder_pkg;

  localparam int MAC_W_ELEMENT  = 10;
  localparam int MAC_N_ELEM     = 32;
  localparam int MAC_W_DATA     = 2 * MAC_N_ELEM * MAC_W_ELEMENT;
  localparam int MAC_W_FIELD    = 18;
  localparam int MAC_BEATS_FP16 = 8;
  localparam int MAC_BEATS_8B   = 4;

  // Canonical zero element: is_zero set, sign and payload cleared
  localparam logic [MAC_W_FIELD-1:0]   MAC_ZERO16 = 18'h20000;
  localparam logic [MAC_W_ELEMENT-1:0] MAC_ZERO8  = 10'h200;

  typedef enum logic [1:0] {
    MAC_FP16 = 2'd0,
    MAC_FP8  = 2'd1,
    MAC_INT8 = 2'd2
  } mac_datatype;

  typedef struct packed {
    logic [MAC_W_DATA-1:0] data;
  } mac_lane_ifm_port;

  typedef struct packed {
    logic [15:0] words_sent;
    logic [15:0] pad_words;
  } mac_enc_monitor;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } enc_state_e;

  function automatic logic [2:0] last_beat(input mac_datatype dt);
    return (dt == MAC_FP16) ? 3'(MAC_BEATS_FP16 - 1) : 3'(MAC_BEATS_8B - 1);
  endfunction

endpackage

// File: rtl/mac_ifm_encoder_if.sv
// Raw-beat input and lane-word output handshakes of the IFM encoder.
interface mac_ifm_encoder_if #(parameter int W_BEAT = 64);
  import mac_ifm_encoder_pkg::*;

  logic              enc_i_raw_valid;
  logic              enc_o_raw_ready;
  logic [W_BEAT-1:0] enc_i_raw_data;
  logic              enc_i_raw_last;
  logic              enc_i_ofm_ready;
  logic              enc_o_ofm_valid;
  mac_lane_ifm_port  enc_o_ifm;

  modport master (
    output enc_i_raw_valid, enc_i_raw_data, enc_i_raw_last, enc_i_ofm_ready,
    input  enc_o_raw_ready, enc_o_ofm_valid, enc_o_ifm
  );

  modport slave (
    input  enc_i_raw_valid, enc_i_raw_data, enc_i_raw_last, enc_i_ofm_ready,
    output enc_o_raw_ready, enc_o_ofm_valid, enc_o_ifm
  );

endinterface

// File: rtl/mac_ifm_encoder_elem_encoder.sv
// Combinational encoder for one raw IFM value into the lane's unpacked
// element field; 8-bit types occupy only the low 10 bits.
module mac_elem_encoder
  import mac_ifm_encoder_pkg::*;
(
  input  logic [15:0]            raw,
  input  mac_datatype            datatype,
  output logic [MAC_W_FIELD-1:0] field
);

  logic [7:0] mag;

  // -128 wraps to 0x80, which is the desired magnitude
  assign mag = raw[7] ? (~raw[7:0] + 8'd1) : raw[7:0];

  always_comb begin
    field = '0;
    case (datatype)
      MAC_FP16: begin
        if (raw[14:0] == 15'd0) field = MAC_ZERO16;
        else field = {1'b0, raw[15], (raw[14:10] == 5'd0) ? 5'd1 : raw[14:10],
                      raw[14:10] != 5'd0, raw[9:0]};
      end
      MAC_FP8: begin
        if (raw[6:0] == 7'd0) field = {8'h00, MAC_ZERO8};
        else field = {8'h00, 1'b0, raw[7], (raw[6:3] == 4'd0) ? 4'd1 : raw[6:3],
                      raw[6:3] != 4'd0, raw[2:0]};
      end
      MAC_INT8: begin
        if (raw[7:0] == 8'd0) field = {8'h00, MAC_ZERO8};
        else field = {8'h00, 1'b0, raw[7], mag};
      end
      default: field = '0;
    endcase
  end

endmodule

// File: rtl/mac_ifm_encoder.sv
// Streaming IFM front-end for one MAC lane: encodes raw beats, packs them
// into a 32-element lane word and hands it over a valid/ready register.
module mac_ifm_encoder
  import mac_ifm_encoder_pkg::*;
#(
  parameter int N_ELEM = 32,
  parameter int W_BEAT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mac_datatype       enc_i_datatype,
  mac_ifm_encoder_if.slave  bus,
  output mac_enc_monitor    enc_o_monitor
);

  localparam int N_ENC   = W_BEAT / 8;
  localparam int SLICE_W = N_ENC * MAC_W_ELEMENT;
  localparam int W_DATA  = 2 * N_ELEM * MAC_W_ELEMENT;
  localparam int N_SLOT  = W_DATA / SLICE_W;
  localparam int CW      = $clog2(N_SLOT);

  enc_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  mac_datatype       dt_q;
  mac_datatype       dt_eff;
  logic [W_DATA-1:0] pack_q;
  logic [W_DATA-1:0] word_next;
  mac_lane_ifm_port  ifm_q;
  logic              valid_q;
  logic              raw_ready_q;
  mac_enc_monitor    mon_q;

  logic [N_ENC-1:0][15:0]            raw16;
  logic [N_ENC-1:0][MAC_W_FIELD-1:0] fields;
  logic [SLICE_W-1:0]                beat_slice;
  logic [SLICE_W-1:0]                pad_slice;
  logic [CW-1:0]                     lastb;
  logic                              complete;
  logic                              is_pad;
  logic                              out_free;

  // The first beat of a word decodes with the live datatype; the rest use the latched one
  assign dt_eff   = (cnt_q == '0) ? enc_i_datatype : dt_q;
  assign lastb    = CW'(last_beat(dt_eff));
  assign complete = (cnt_q == lastb) || bus.enc_i_raw_last;
  assign is_pad   = bus.enc_i_raw_last && (cnt_q != lastb);
  assign out_free = !valid_q || bus.enc_i_ofm_ready;

  for (genvar k = 0; k < N_ENC; k++) begin : g_enc
    if (k < N_ENC / 2) begin : g_wide
      assign raw16[k] = (dt_eff == MAC_FP16) ? bus.enc_i_raw_data[k*16 +: 16]
                                             : {8'h00, bus.enc_i_raw_data[k*8 +: 8]};
    end else begin : g_narrow
      assign raw16[k] = {8'h00, bus.enc_i_raw_data[k*8 +: 8]};
    end
    mac_elem_encoder u_enc (
      .raw      (raw16[k]),
      .datatype (dt_eff),
      .field    (fields[k])
    );
  end

  // One beat always covers SLICE_W bits: 4 x 20-bit FP16 slots or 8 x 10-bit slots
  always_comb begin
    beat_slice = '0;
    pad_slice  = '0;
    if (dt_eff == MAC_FP16) begin
      for (int k = 0; k < N_ENC / 2; k++) begin
        beat_slice[k*2*MAC_W_ELEMENT +: 2*MAC_W_ELEMENT] = {2'b00, fields[k]};
        pad_slice [k*2*MAC_W_ELEMENT +: 2*MAC_W_ELEMENT] = {2'b00, MAC_ZERO16};
      end
    end else begin
      for (int k = 0; k < N_ENC; k++) begin
        beat_slice[k*MAC_W_ELEMENT +: MAC_W_ELEMENT] = fields[k][MAC_W_ELEMENT-1:0];
        pad_slice [k*MAC_W_ELEMENT +: MAC_W_ELEMENT] = MAC_ZERO8;
      end
    end
  end

  // Earlier beats from the buffer, this beat live, later beats of the word as zero pads
  always_comb begin
    word_next = '0;
    for (int b = 0; b < N_SLOT; b++) begin
      if (CW'(b) < cnt_q)       word_next[b*SLICE_W +: SLICE_W] = pack_q[b*SLICE_W +: SLICE_W];
      else if (CW'(b) == cnt_q) word_next[b*SLICE_W +: SLICE_W] = beat_slice;
      else if (CW'(b) <= lastb) word_next[b*SLICE_W +: SLICE_W] = pad_slice;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      dt_q        <= MAC_FP16;
      pack_q      <= '0;
      ifm_q       <= '0;
      valid_q     <= 1'b0;
      raw_ready_q <= 1'b1;
      mon_q       <= '0;
    end else begin
      if (valid_q && bus.enc_i_ofm_ready) begin
        valid_q          <= 1'b0;
        mon_q.words_sent <= mon_q.words_sent + 16'd1;
      end
      case (state_q)
        ST_FILL: begin
          if (bus.enc_i_raw_valid) begin
            pack_q <= word_next;
            if (cnt_q == '0) dt_q <= enc_i_datatype;
            if (complete) begin
              cnt_q <= '0;
              if (is_pad) mon_q.pad_words <= mon_q.pad_words + 16'd1;
              if (out_free) begin
                valid_q    <= 1'b1;
                ifm_q.data <= word_next;
              end else begin
                state_q     <= ST_HOLD;
                raw_ready_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_free) begin
            valid_q     <= 1'b1;
            ifm_q.data  <= pack_q;
            state_q     <= ST_FILL;
            raw_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign bus.enc_o_raw_ready = raw_ready_q;
  assign bus.enc_o_ofm_valid = valid_q;
  assign bus.enc_o_ifm       = ifm_q;
  assign enc_o_monitor       = mon_q;

endmodule

// File: tb/tb_mac_ifm_encoder.sv
// Directed scoreboard bench for mac_ifm_encoder: stimulus pushes expected
// lane words, a negedge monitor pops and compares on each output handshake.
module tb_mac_ifm_encoder;
  import mac_ifm_encoder_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  mac_datatype    dt;
  mac_enc_monitor mon;

  always #5 clk = ~clk;

  mac_ifm_encoder_if #(.W_BEAT(64)) bus();

  mac_ifm_encoder #(.N_ELEM(32), .W_BEAT(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enc_i_datatype (dt),
    .bus            (bus.slave),
    .enc_o_monitor  (mon)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [MAC_W_DATA-1:0] exp_q[$];
  logic [MAC_W_DATA-1:0] e;

  task automatic chk(input string nm, input logic [MAC_W_DATA-1:0] act,
                     input logic [MAC_W_DATA-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [MAC_W_DATA-1:0] w16(input logic [17:0] f);
    logic [MAC_W_DATA-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*20 +: 18] = f;
    return r;
  endfunction

  function automatic logic [MAC_W_DATA-1:0] w8(input logic [9:0] f);
    logic [MAC_W_DATA-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*10 +: 10] = f;
    return r;
  endfunction

  function automatic logic [MAC_W_DATA-1:0] put16(input logic [MAC_W_DATA-1:0] w,
                                                  input int i, input logic [17:0] f);
    logic [MAC_W_DATA-1:0] r;
    r = w;
    r[i*20 +: 18] = f;
    return r;
  endfunction

  function automatic logic [MAC_W_DATA-1:0] put8(input logic [MAC_W_DATA-1:0] w,
                                                 input int i, input logic [9:0] f);
    logic [MAC_W_DATA-1:0] r;
    r = w;
    r[i*10 +: 10] = f;
    return r;
  endfunction

  // Monitor: pops on every handshake, and checks the word holds while stalled
  initial begin
    logic                  stall_prev;
    logic [MAC_W_DATA-1:0] word_prev;
    stall_prev = 1'b0;
    word_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) chk("hold_stable", bus.enc_o_ifm.data, word_prev);
        if (bus.enc_o_ofm_valid && bus.enc_i_ofm_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %0h expected none", bus.enc_o_ifm.data);
          end else begin
            chk("word", bus.enc_o_ifm.data, exp_q.pop_front());
          end
        end
        stall_prev = bus.enc_o_ofm_valid && !bus.enc_i_ofm_ready;
        word_prev  = bus.enc_o_ifm.data;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    bus.enc_i_raw_valid = 1'b1;
    bus.enc_i_raw_data  = d;
    bus.enc_i_raw_last  = l;
    @(negedge clk);
    while (!bus.enc_o_raw_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL raw_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.enc_i_raw_valid = 1'b0;
    bus.enc_i_raw_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(1);
  endtask

  initial begin
    bus.enc_i_raw_valid = 1'b0;
    bus.enc_i_raw_data  = '0;
    bus.enc_i_raw_last  = 1'b0;
    bus.enc_i_ofm_ready = 1'b1;
    dt = MAC_FP16;
    tick(3);
    chk("rst_valid",     MAC_W_DATA'(bus.enc_o_ofm_valid), MAC_W_DATA'(0));
    chk("rst_ifm",       bus.enc_o_ifm.data, '0);
    chk("rst_raw_ready", MAC_W_DATA'(bus.enc_o_raw_ready), MAC_W_DATA'(1));
    chk("rst_monitor",   MAC_W_DATA'(mon), MAC_W_DATA'(0));
    rst_n = 1'b1;
    tick(1);

    // FP16 1.0 everywhere, checking one-cycle latency after the 8th beat
    exp_q.push_back(w16(18'h07C00));
    for (int b = 0; b < 8; b++) beat(64'h3C00_3C00_3C00_3C00, 1'b0);
    chk("fp16_latency", MAC_W_DATA'(bus.enc_o_ofm_valid), MAC_W_DATA'(1));
    drain();

    // INT8 mix: -3, 0, -128, 1, 127, -1, 0, 0
    dt = MAC_INT8;
    e = w8(10'h200);
    e = put8(e, 0, 10'h103); e = put8(e, 2, 10'h180); e = put8(e, 3, 10'h001);
    e = put8(e, 4, 10'h07F); e = put8(e, 5, 10'h101);
    exp_q.push_back(e);
    beat(64'h0000_FF7F_0180_00FD, 1'b0);
    for (int b = 0; b < 3; b++) beat(64'h0, 1'b0);
    drain();

    // FP8 E4M3: 0x38, 0x01, 0x80, 0x00, 0xB8, 0x7F, 0x08, 0x00; last on the full word
    dt = MAC_FP8;
    e = w8(10'h200);
    e = put8(e, 0, 10'h078); e = put8(e, 1, 10'h011); e = put8(e, 4, 10'h178);
    e = put8(e, 5, 10'h0FF); e = put8(e, 6, 10'h018);
    exp_q.push_back(e);
    beat(64'h0008_7FB8_0080_0138, 1'b0);
    beat(64'h0, 1'b0);
    beat(64'h0, 1'b0);
    beat(64'h0, 1'b1);
    drain();
    chk("fp8_no_pad", MAC_W_DATA'(mon.pad_words), MAC_W_DATA'(0));

    // FP16 early last on beat 2: elements 12..31 padded
    dt = MAC_FP16;
    e = w16(18'h20000);
    for (int i = 0; i < 9; i++) e = put16(e, i, 18'h07C00);
    e = put16(e, 10, 18'h18400);
    e = put16(e, 11, 18'h00801);
    exp_q.push_back(e);
    beat(64'h3C00_3C00_3C00_3C00, 1'b0);
    beat(64'h3C00_3C00_3C00_3C00, 1'b0);
    beat(64'h0001_C000_8000_3C00, 1'b1);
    drain();
    chk("pad_words", MAC_W_DATA'(mon.pad_words), MAC_W_DATA'(1));

    // Counter restarted: a full 8-beat word of 2.0
    exp_q.push_back(w16(18'h08400));
    for (int b = 0; b < 8; b++) beat(64'h4000_4000_4000_4000, 1'b0);
    drain();

    // Back-pressure across two INT8 words: second word parks in HOLD
    dt = MAC_INT8;
    bus.enc_i_ofm_ready = 1'b0;
    exp_q.push_back(w8(10'h001));
    exp_q.push_back(w8(10'h002));
    for (int b = 0; b < 4; b++) beat(64'h0101_0101_0101_0101, 1'b0);
    for (int b = 0; b < 4; b++) beat(64'h0202_0202_0202_0202, 1'b0);
    chk("hold_raw_ready", MAC_W_DATA'(bus.enc_o_raw_ready), MAC_W_DATA'(0));
    tick(5);
    chk("hold_raw_ready_late", MAC_W_DATA'(bus.enc_o_raw_ready), MAC_W_DATA'(0));
    chk("hold_valid", MAC_W_DATA'(bus.enc_o_ofm_valid), MAC_W_DATA'(1));
    bus.enc_i_ofm_ready = 1'b1;
    drain();
    chk("words_sent", MAC_W_DATA'(mon.words_sent), MAC_W_DATA'(7));
    chk("released_raw_ready", MAC_W_DATA'(bus.enc_o_raw_ready), MAC_W_DATA'(1));

    // Reset after the third FP16 beat discards the partial word
    dt = MAC_FP16;
    for (int b = 0; b < 3; b++) beat(64'h3C00_3C00_3C00_3C00, 1'b0);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_valid", MAC_W_DATA'(bus.enc_o_ofm_valid), MAC_W_DATA'(0));
    chk("midrst_raw_ready", MAC_W_DATA'(bus.enc_o_raw_ready), MAC_W_DATA'(1));
    chk("midrst_monitor", MAC_W_DATA'(mon), MAC_W_DATA'(0));
    rst_n = 1'b1;
    tick(3);
    chk("postrst_valid", MAC_W_DATA'(bus.enc_o_ofm_valid), MAC_W_DATA'(0));

    // Datatype flip mid-word is ignored until the next word
    dt = MAC_INT8;
    exp_q.push_back(w8(10'h005));
    beat(64'h0505_0505_0505_0505, 1'b0);
    beat(64'h0505_0505_0505_0505, 1'b0);
    dt = MAC_FP16;
    beat(64'h0505_0505_0505_0505, 1'b0);
    beat(64'h0505_0505_0505_0505, 1'b0);
    drain();
    exp_q.push_back(w16(18'h07C00));
    for (int b = 0; b < 8; b++) beat(64'h3C00_3C00_3C00_3C00, 1'b0);
    drain();
    chk("words_sent_after_rst", MAC_W_DATA'(mon.words_sent), MAC_W_DATA'(2));

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
